gain_stepper: RTL

GAIN_STEPPER -- requirements
Module: gain_stepper

---
 rtl/gain_stepper.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gain_stepper.sv
// gain_stepper: up/down button gain control with hold-to-repeat and a
// handshaked set-gain request (IDLE -> ISSUE -> GUARD -> WAIT).
`default_nettype none

module gain_stepper #(
  parameter int GAIN_W        = 8,
  parameter int MIN_DB        = -16,
  parameter int MAX_DB        = 44,
  parameter int STEP_DB       = 4,
  parameter int RESET_DB      = 0,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 20000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_up_i,
  input  logic                     btn_dn_i,
  input  logic                     set_ready_i,
  output logic signed [GAIN_W-1:0] gain_dB_o,
  output logic                     set_gain_o,
  output logic                     busy_o,
  output logic                     at_limit_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_CYCLES);

  localparam logic signed [GAIN_W:0]   MIN_X   = (GAIN_W+1)'(MIN_DB);
  localparam logic signed [GAIN_W:0]   MAX_X   = (GAIN_W+1)'(MAX_DB);
  localparam logic signed [GAIN_W:0]   STEP_X  = (GAIN_W+1)'(STEP_DB);
  localparam logic signed [GAIN_W-1:0] MIN_G   = GAIN_W'(MIN_DB);
  localparam logic signed [GAIN_W-1:0] MAX_G   = GAIN_W'(MAX_DB);
  localparam logic signed [GAIN_W-1:0] RESET_G = GAIN_W'(RESET_DB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // One extra bit of headroom keeps gain +/- step from overflowing
  function automatic logic signed [GAIN_W-1:0] next_gain(
    input logic signed [GAIN_W-1:0] g,
    input logic                     up
  );
    logic signed [GAIN_W:0]   gx;
    logic signed [GAIN_W:0]   sum;
    logic signed [GAIN_W-1:0] res;
    gx = {g[GAIN_W-1], g};
    if (up) begin
      sum = gx + STEP_X;
      if (sum > MAX_X) res = (WRAP != 0) ? MIN_G : MAX_G;
      else             res = sum[GAIN_W-1:0];
    end else begin
      sum = gx - STEP_X;
      if (sum < MIN_X) res = (WRAP != 0) ? MAX_G : MIN_G;
      else             res = sum[GAIN_W-1:0];
    end
    return res;
  endfunction

  state_t                     state_q, state_d;
  logic signed [GAIN_W-1:0]   gain_q, gain_d;
  logic                       set_q, set_d;
  logic                       busy_q, busy_d;
  logic                       at_limit_q, at_limit_d;
  logic                       pend_v_q, pend_v_d;
  logic                       pend_up_q, pend_up_d;
  logic                       btn_up_q, btn_dn_q;
  logic                       hold_act_q, hold_act_d;
  logic                       hold_up_q, hold_up_d;
  logic                       rep_q, rep_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       up_press, dn_press, both_high, held;
  logic                       step_v, step_up;
  logic                       cand_v, cand_up;
  logic signed [GAIN_W-1:0]   ng;

  // Press detection and hold/auto-repeat timing
  always_comb begin
    up_press   = btn_up_i & ~btn_up_q;
    dn_press   = btn_dn_i & ~btn_dn_q;
    both_high  = btn_up_i & btn_dn_i;
    held       = hold_up_q ? btn_up_i : btn_dn_i;
    hold_act_d = hold_act_q;
    hold_up_d  = hold_up_q;
    rep_d      = rep_q;
    cnt_d      = cnt_q;
    step_v     = 1'b0;
    step_up    = 1'b0;
    if (both_high) begin
      hold_act_d = 1'b0;
      rep_d      = 1'b0;
    end else if (up_press || dn_press) begin
      step_v     = 1'b1;
      step_up    = up_press;
      hold_act_d = 1'b1;
      hold_up_d  = up_press;
      rep_d      = 1'b0;
      cnt_d      = CNT_W'(1);
    end else if (hold_act_q) begin
      if (!held) begin
        hold_act_d = 1'b0;
        rep_d      = 1'b0;
      end else if ((!rep_q && cnt_q == HOLD_CNT) || (rep_q && cnt_q == REPEAT_CNT)) begin
        step_v  = 1'b1;
        step_up = hold_up_q;
        rep_d   = 1'b1;
        cnt_d   = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    set_d     = 1'b0;
    pend_v_d  = pend_v_q;
    pend_up_d = pend_up_q;
    cand_v    = step_v | pend_v_q;
    cand_up   = step_v ? step_up : pend_up_q;
    ng        = gain_q;

    // While busy, the latest step overwrites whatever was pending
    if (state_q != S_IDLE && step_v) begin
      pend_v_d  = 1'b1;
      pend_up_d = step_up;
    end

    case (state_q)
      S_IDLE: begin
        if (step_v) begin
          ng = next_gain(gain_q, step_up);
          if (ng != gain_q) begin
            gain_d  = ng;
            set_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_GUARD;
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (set_ready_i) begin
          pend_v_d = 1'b0;
          state_d  = S_IDLE;
          if (cand_v) begin
            ng = next_gain(gain_q, cand_up);
            if (ng != gain_q) begin
              gain_d  = ng;
              set_d   = 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    at_limit_d = (gain_d == MIN_G) || (gain_d == MAX_G);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gain_q     <= RESET_G;
      set_q      <= 1'b0;
      busy_q     <= 1'b0;
      at_limit_q <= (RESET_G == MIN_G) || (RESET_G == MAX_G);
      pend_v_q   <= 1'b0;
      pend_up_q  <= 1'b0;
      hold_act_q <= 1'b0;
      hold_up_q  <= 1'b0;
      rep_q      <= 1'b0;
      cnt_q      <= '0;
      // Track the live level so a button held through reset is not a press
      btn_up_q   <= btn_up_i;
      btn_dn_q   <= btn_dn_i;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      set_q      <= set_d;
      busy_q     <= busy_d;
      at_limit_q <= at_limit_d;
      pend_v_q   <= pend_v_d;
      pend_up_q  <= pend_up_d;
      hold_act_q <= hold_act_d;
      hold_up_q  <= hold_up_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      btn_up_q   <= btn_up_i;
      btn_dn_q   <= btn_dn_i;
    end
  end

  assign gain_dB_o  = gain_q;
  assign set_gain_o = set_q;
  assign busy_o     = busy_q;
  assign at_limit_o = at_limit_q;

endmodule

`default_nettype wire
